// File: rtl/trace_capture.sv
// ============================================================================
// Module   : trace_capture
// Brief    : Circular pre-trigger trace buffer with masked value trigger,
//            programmable post-trigger count and 32-bit sliced readout.
//            Define TRACE_TIMESTAMP_EN to store a 16-bit cycle stamp per entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_capture #(
    parameter int DATA_WIDTH = 72,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] smp_data,
    input  logic                  smp_valid,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [ADDR_WIDTH-1:0] post_count,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [7:0]            rd_word,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic [1:0]            state,
    output logic                  triggered,
    output logic [ADDR_WIDTH:0]   sample_count,
    output logic [ADDR_WIDTH-1:0] trig_idx
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef TRACE_TIMESTAMP_EN
    localparam int SW = DATA_WIDTH + 16;
`else
    localparam int SW = DATA_WIDTH;
`endif
    localparam int NSLICE = (SW + 31) / 32;

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_ARMED = 2'b01;
    localparam logic [1:0] c_TRIG  = 2'b10;
    localparam logic [1:0] c_DONE  = 2'b11;
    localparam logic [ADDR_WIDTH:0] c_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  trig_q, trig_d;
    logic [ADDR_WIDTH-1:0] trig_phys_q, trig_phys_d;
    logic [ADDR_WIDTH-1:0] trig_idx_q, trig_idx_d;
    logic [ADDR_WIDTH-1:0] post_q, post_d;
    logic [31:0]           rd_data_q;
    logic                  rd_valid_q;

    logic [SW-1:0]         mem_q [DEPTH];
    logic [SW-1:0]         w_entry;
    logic                  w_we;
    logic                  w_match;
    logic                  w_busy;
    logic [ADDR_WIDTH-1:0] w_start;
    logic [ADDR_WIDTH-1:0] w_rd_phys;
    logic [NSLICE*32-1:0]  w_rd_pad;
    logic [31:0]           w_slice;

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;

    // Arm zeroes the stamp in its own cycle, so the first post-arm cycle reads 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= (arm ? 16'd0 : ts_q) + 16'd1;
    end

    assign w_entry = {ts_q, smp_data};
`else
    assign w_entry = smp_data;
`endif

    assign w_match = smp_valid && (((smp_data ^ trig_value) & trig_mask) == '0);
    assign w_busy  = (state_q == c_ARMED) || (state_q == c_TRIG);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        trig_d      = trig_q;
        trig_phys_d = trig_phys_q;
        trig_idx_d  = trig_idx_q;
        post_d      = post_q;
        w_we        = 1'b0;
        if (abort) begin
            if (w_busy) state_d = c_DONE;
        end else if (arm) begin
            state_d     = c_ARMED;
            wr_ptr_d    = '0;
            count_d     = '0;
            trig_d      = 1'b0;
            trig_phys_d = '0;
            trig_idx_d  = '0;
            post_d      = '0;
        end else if (w_busy && smp_valid) begin
            w_we     = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (count_q != c_FULL) count_d = count_q + (ADDR_WIDTH+1)'(1);
            if (state_q == c_ARMED) begin
                if (w_match) begin
                    trig_d      = 1'b1;
                    trig_phys_d = wr_ptr_q;
                    post_d      = post_count;
                    state_d     = (post_count == '0) ? c_DONE : c_TRIG;
                end
            end else begin
                post_d = post_q - ADDR_WIDTH'(1);
                if (post_q == ADDR_WIDTH'(1)) state_d = c_DONE;
            end
        end
        // Trigger index is relative to the oldest entry as the buffer freezes.
        if ((state_d == c_DONE) && (state_q != c_DONE) && trig_d)
            trig_idx_d = trig_phys_d - (count_d[ADDR_WIDTH] ? wr_ptr_d : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= c_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            trig_q      <= 1'b0;
            trig_phys_q <= '0;
            trig_idx_q  <= '0;
            post_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            trig_q      <= trig_d;
            trig_phys_q <= trig_phys_d;
            trig_idx_q  <= trig_idx_d;
            post_q      <= post_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) mem_q[wr_ptr_q] <= w_entry;
    end

    assign w_start   = count_q[ADDR_WIDTH] ? wr_ptr_q : '0;
    assign w_rd_phys = rd_addr + w_start;

    always_comb begin
        w_rd_pad         = '0;
        w_rd_pad[SW-1:0] = mem_q[w_rd_phys];
        w_slice          = '0;
        for (int k = 0; k < NSLICE; k++) begin
            if (rd_word == 8'(k)) w_slice = w_rd_pad[32*k +: 32];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= w_slice;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign state        = state_q;
    assign triggered    = trig_q;
    assign sample_count = count_q;
    assign trig_idx     = trig_idx_q;

endmodule

`default_nettype wire
